// File: rtl/nr_div_pkg.sv
// Shared types and constants for the Newton-Raphson fixed-point divider.
// Constant helpers take the operand width as an argument and return a wide
// container that callers slice down to the width they need.
package nr_div_pkg;

   localparam int NR_MAX_W = 128;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      NORM   = 3'd1,
      SEED   = 3'd2,
      ITER_A = 3'd3,
      ITER_B = 3'd4,
      SCALE  = 3'd5,
      DONE   = 3'd6
   } nr_state_t;

   // 48/17 in Q2.w, rounded to nearest
   function automatic logic [NR_MAX_W-1:0] seed_c48(input int w);
      logic [NR_MAX_W-1:0] num;
      num = (NR_MAX_W'(48) << w) + NR_MAX_W'(8);
      return num / NR_MAX_W'(17);
   endfunction

   // 32/17 in Q2.w, rounded to nearest
   function automatic logic [NR_MAX_W-1:0] seed_c32(input int w);
      logic [NR_MAX_W-1:0] num;
      num = (NR_MAX_W'(32) << w) + NR_MAX_W'(8);
      return num / NR_MAX_W'(17);
   endfunction

   // 2^(w-1)-1 : most-positive w-bit two's complement value
   function automatic logic [NR_MAX_W-1:0] most_pos(input int w);
      return (NR_MAX_W'(1) << (w - 1)) - NR_MAX_W'(1);
   endfunction

   // 2^(w-1) : bit pattern of the most-negative w-bit value
   function automatic logic [NR_MAX_W-1:0] most_neg(input int w);
      return NR_MAX_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/nr_lzc.sv
// Leading-zero counter. An all-zero input reports DATA_W.
module nr_lzc #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]       a,
   output logic [$clog2(DATA_W):0] lz
);

   localparam int LZW = $clog2(DATA_W) + 1;

   // scan upward so the highest set bit is the last one to write lz
   always_comb begin
      lz = LZW'(DATA_W);
      for (int i = 0; i < DATA_W; i++) begin
         if (a[i]) lz = LZW'(DATA_W - 1 - i);
      end
   end

endmodule

// File: rtl/nr_div.sv
// Signed Q(DATA_W-FRAC_BITS).FRAC_BITS divider using a Newton-Raphson
// reciprocal on one time-shared (DATA_W+2)x(DATA_W+2) signed multiplier.
// Optional build macro NR_DIV_SAT_EN: saturate q on overflow instead of
// returning the wrapped low bits.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | in_ready high, waiting for an operand pair
//   NORM   | register sign, magnitudes and leading-zero count of |ds|
//   SEED   | normalise divisor to d in [0.5,1), x0 = 48/17 - 32/17*d
//   ITER_A | t = 2 - d*x
//   ITER_B | x = x*t, repeats with ITER_A for N_ITER pairs
//   SCALE  | P = |dd|*x, shift to result format, sign, overflow
//   DONE   | out_valid high, result held until out_ready
module nr_div
   import nr_div_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int FRAC_BITS = 24,
   parameter int N_ITER    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] dd,
   input  logic [DATA_W-1:0] ds,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] q,
   output logic              dz,
   output logic              ovf
);

   localparam int XW  = DATA_W + 2;          // Q2.DATA_W working width
   localparam int PW  = 2 * XW;              // full multiplier product
   localparam int LZW = $clog2(DATA_W) + 1;
   localparam int SHW = $clog2(PW) + 1;
   localparam int ITW = 3;

   localparam logic [NR_MAX_W-1:0] C48_FULL = seed_c48(DATA_W);
   localparam logic [NR_MAX_W-1:0] C32_FULL = seed_c32(DATA_W);
   localparam logic [NR_MAX_W-1:0] MAXP_FULL = most_pos(DATA_W);
   localparam logic [NR_MAX_W-1:0] MINN_FULL = most_neg(DATA_W);

   localparam logic [XW-1:0]     SEED_C48 = C48_FULL[XW-1:0];
   localparam logic [XW-1:0]     SEED_C32 = C32_FULL[XW-1:0];
   localparam logic [XW-1:0]     TWO_Q    = {2'b10, {DATA_W{1'b0}}};
   localparam logic [DATA_W-1:0] MOST_POS = MAXP_FULL[DATA_W-1:0];
   localparam logic [DATA_W-1:0] MOST_NEG = MINN_FULL[DATA_W-1:0];
   localparam logic [PW-1:0]     LIM_POS  = MAXP_FULL[PW-1:0];
   localparam logic [PW-1:0]     LIM_NEG  = MINN_FULL[PW-1:0];
   localparam logic [SHW-1:0]    SH_BASE  = SHW'(2 * DATA_W - FRAC_BITS);

   nr_state_t state, state_nxt;

   logic [DATA_W-1:0] dd_r, ds_r;
   logic              sign_r, dz_r;
   logic [DATA_W-1:0] add_r, ads_r;
   logic [LZW-1:0]    lz_r;
   logic [DATA_W-1:0] d_r;
   logic [XW-1:0]     x_r, t_r;
   logic [ITW-1:0]    it_cnt;

   logic [DATA_W-1:0] abs_dd, abs_ds, d_seed;
   logic [LZW-1:0]    lz_w;
   logic signed [XW-1:0] mul_a, mul_b;
   logic signed [PW-1:0] mul_p;
   logic [PW-1:0]     p_u;
   logic [XW-1:0]     prod_q, x_seed, t_nxt;
   logic [SHW-1:0]    sh;
   logic [PW-1:0]     mag;
   logic [DATA_W-1:0] res_wrap, q_nxt;
   logic              ovf_nxt;

   // operand magnitudes; the most-negative value maps onto 2^(DATA_W-1)
   always_comb begin
      abs_dd = dd_r[DATA_W-1] ? -dd_r : dd_r;
      abs_ds = ds_r[DATA_W-1] ? -ds_r : ds_r;
      d_seed = ads_r << lz_r;
   end

   nr_lzc #(
      .DATA_W (DATA_W)
   ) u_lzc (
      .a  (abs_ds),
      .lz (lz_w)
   );

   // operand select for the single shared multiplier
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state)
         SEED: begin
            mul_a = SEED_C32;
            mul_b = {2'b00, d_seed};
         end
         ITER_A: begin
            mul_a = {2'b00, d_r};
            mul_b = x_r;
         end
         ITER_B: begin
            mul_a = x_r;
            mul_b = t_r;
         end
         SCALE: begin
            mul_a = {2'b00, add_r};
            mul_b = x_r;
         end
         default: begin
            mul_a = '0;
            mul_b = '0;
         end
      endcase
   end

   assign mul_p = mul_a * mul_b;
   assign p_u   = mul_p;

   // Q2.DATA_W truncation of the product plus seed/iteration arithmetic;
   // all operands are non-negative, so plain modular subtraction is exact
   always_comb begin
      prod_q = p_u[DATA_W +: XW];
      x_seed = SEED_C48 - prod_q;
      t_nxt  = TWO_Q - prod_q;
   end

   // final scaling, sign application and overflow/zero-divide handling
   always_comb begin
      sh       = SH_BASE - SHW'(lz_r);
      mag      = p_u >> sh;
      res_wrap = sign_r ? -mag[DATA_W-1:0] : mag[DATA_W-1:0];
      ovf_nxt  = !dz_r && (sign_r ? (mag > LIM_NEG) : (mag > LIM_POS));
      q_nxt    = res_wrap;
      if (dz_r) begin
         // with ds == 0 the sign is just the sign of dd
         q_nxt = sign_r ? MOST_NEG : MOST_POS;
      end else if (ovf_nxt) begin
`ifdef NR_DIV_SAT_EN
         q_nxt = sign_r ? MOST_NEG : MOST_POS;
`else
         q_nxt = res_wrap;
`endif
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = NORM;
         NORM:    state_nxt = SEED;
         SEED:    state_nxt = ITER_A;
         ITER_A:  state_nxt = ITER_B;
         ITER_B:  state_nxt = (it_cnt == '0) ? SCALE : ITER_A;
         SCALE:   state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // handshake outputs
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // datapath registers, each loaded only in the state that owns it
   always_ff @(posedge clk) begin
      if (rst) begin
         dd_r   <= '0;
         ds_r   <= '0;
         sign_r <= 1'b0;
         dz_r   <= 1'b0;
         add_r  <= '0;
         ads_r  <= '0;
         lz_r   <= '0;
         d_r    <= '0;
         x_r    <= '0;
         t_r    <= '0;
         it_cnt <= '0;
         q      <= '0;
         dz     <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  dd_r <= dd;
                  ds_r <= ds;
               end
            end
            NORM: begin
               sign_r <= dd_r[DATA_W-1] ^ ds_r[DATA_W-1];
               add_r  <= abs_dd;
               ads_r  <= abs_ds;
               lz_r   <= lz_w;
               dz_r   <= (ds_r == '0);
            end
            SEED: begin
               d_r    <= d_seed;
               x_r    <= x_seed;
               it_cnt <= ITW'(N_ITER - 1);
            end
            ITER_A: begin
               t_r <= t_nxt;
            end
            ITER_B: begin
               x_r <= prod_q;
               if (it_cnt != '0) it_cnt <= it_cnt - 3'd1;
            end
            SCALE: begin
               q   <= q_nxt;
               dz  <= dz_r;
               ovf <= ovf_nxt;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nr_div.sv
// Bench for nr_div: directed operand pairs, arithmetic reference model,
// per-cycle output checker. Honours NR_DIV_SAT_EN like the design.
module tb_nr_div;

   localparam int DATA_W    = 32;
   localparam int FRAC_BITS = 24;
   localparam int N_ITER    = 3;
   localparam int LAT       = 4 + 2 * N_ITER;
   localparam int PERIOD    = 5 + 2 * N_ITER;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] dd, ds;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] q;
   logic              dz, ovf;

   nr_div #(
      .DATA_W    (DATA_W),
      .FRAC_BITS (FRAC_BITS),
      .N_ITER    (N_ITER)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dd        (dd),
      .ds        (ds),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q         (q),
      .dz        (dz),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] q;
      logic        dz;
      logic        ovf;
      longint      tol;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   acc_log[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   n_sent = 0;
   int   n_done = 0;
   int   n_abort = 0;

   logic [31:0] last_q;
   logic        last_dz, last_ovf;
   int          last_lat;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input longint act, input longint req);
      n_chk++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // exact truncated quotient of the fixed-point values, plus flags
   function automatic exp_t model(input logic signed [31:0] a, input logic signed [31:0] b);
      exp_t   e;
      longint num, quo, aq;
      e.q = '0; e.dz = 1'b0; e.ovf = 1'b0; e.tol = 2; e.acc = 0;
      if (b == 0) begin
         e.dz  = 1'b1;
         e.q   = (a >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
         e.tol = 0;
         return e;
      end
      num = longint'(a) <<< FRAC_BITS;
      quo = num / longint'(b);
      e.q = quo[31:0];
      if (quo > 64'sd2147483647 || quo < -64'sd2147483648) begin
         e.ovf = 1'b1;
`ifdef NR_DIV_SAT_EN
         e.q   = (quo > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
         e.tol = 0;
`else
         aq    = (quo < 0) ? -quo : quo;
         e.tol = (aq >>> 26) + 4;
`endif
      end
      return e;
   endfunction

   // output checker: every cycle out_valid is high
   exp_t        cur;
   bit          seen_first = 0;
   logic [31:0] held_q;
   logic        held_dz, held_ovf;
   logic [31:0] dq;
   longint      adiff;
   int          lat;

   always @(negedge clk) begin
      if (rst) begin
         seen_first = 0;
      end else if (out_valid) begin
         chk(exp_q.size() != 0, "spurious_out_valid", 1, 0);
         if (exp_q.size() != 0) begin
            cur = exp_q[0];
            if (!seen_first) begin
               lat = cyc + 1 - cur.acc;
               chk(lat == LAT, "latency", lat, LAT);
               last_lat   = lat;
               seen_first = 1;
               held_q     = q;
               held_dz    = dz;
               held_ovf   = ovf;
            end else begin
               chk(q == held_q && dz == held_dz && ovf == held_ovf, "hold_stable", q, held_q);
            end
            chk(in_ready == 1'b0, "in_ready_in_done", in_ready, 0);
            chk(dz == cur.dz, "dz", dz, cur.dz);
            chk(ovf == cur.ovf, "ovf", ovf, cur.ovf);
            dq    = q - cur.q;
            adiff = longint'($signed(dq));
            if (adiff < 0) adiff = -adiff;
            chk(adiff <= cur.tol, "quotient", q, cur.q);
            last_q   = q;
            last_dz  = dz;
            last_ovf = ovf;
            if (out_ready) begin
               void'(exp_q.pop_front());
               seen_first = 0;
               n_done++;
            end
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   guard;
      @(posedge clk); #2;
      in_valid = 1'b1;
      dd = a;
      ds = b;
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(posedge clk); #2;
         guard++;
      end
      chk(guard < 200, "accept_timeout", guard, 200);
      e     = model(a, b);
      e.acc = cyc + 1;
      exp_q.push_back(e);
      acc_log.push_back(cyc + 1);
      n_sent++;
      @(posedge clk); #2;
      in_valid = 1'b0;
      dd = $urandom();
      ds = $urandom();
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 500) begin
         @(posedge clk); #2;
         guard++;
      end
      chk(guard < 500, "drain_timeout", guard, 500);
      @(posedge clk); #2;
   endtask

   localparam int NV = 9;
   logic [31:0] vdd [NV] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000,
                             32'h0580_0000, 32'hF900_0000, 32'h0000_0001, 32'h1234_5678,
                             32'hFF00_0000};
   logic [31:0] vds [NV] = '{32'h0100_0000, 32'h7FFF_FFFF, 32'h0100_0000, 32'h0000_0000,
                             32'h0040_0000, 32'h0300_0000, 32'h7FFF_FFFF, 32'h0000_0000,
                             32'h0000_4000};

   exp_t m;

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dd = '0; ds = '0;

      m = model(32'h0100_0000, 32'h0200_0000);
      chk(m.q == 32'h0080_0000 && !m.dz && !m.ovf, "model_1_div_2", m.q, 32'h0080_0000);
      m = model(32'h0300_0000, 32'hFE80_0000);
      chk(m.q == 32'hFE00_0000 && !m.dz, "model_3_div_m1p5", m.q, 32'hFE00_0000);
      m = model(32'hFF00_0000, 32'h0000_0000);
      chk(m.q == 32'h8000_0000 && m.dz && !m.ovf, "model_dz_neg", m.q, 32'h8000_0000);
      m = model(32'h6400_0000, 32'h0002_8F5C);
      chk(m.ovf == 1'b1, "model_ovf", m.ovf, 1);

      repeat (3) @(posedge clk);
      #2;
      chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
      chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
      chk(q == '0, "rst_q", q, 0);
      chk(dz == 1'b0 && ovf == 1'b0, "rst_flags", {dz, ovf}, 0);
      rst = 1'b0;

      send(32'h0100_0000, 32'h0200_0000);
      drain();
      chk(($signed(last_q - 32'h0080_0000) <= 2) && ($signed(last_q - 32'h0080_0000) >= -2),
          "dut_1_div_2", last_q, 32'h0080_0000);
      chk(last_lat == 10, "dut_latency_10", last_lat, 10);

      send(32'h0300_0000, 32'hFE80_0000);
      drain();
      chk(($signed(last_q - 32'hFE00_0000) <= 2) && ($signed(last_q - 32'hFE00_0000) >= -2) && !last_dz,
          "dut_3_div_m1p5", last_q, 32'hFE00_0000);

      send(32'hFF00_0000, 32'h0000_0000);
      drain();
      chk(last_q == 32'h8000_0000 && last_dz && !last_ovf, "dut_dz_neg", last_q, 32'h8000_0000);
      chk(last_lat == 10, "dut_dz_latency", last_lat, 10);

      send(32'h6400_0000, 32'h0002_8F5C);
      drain();
      chk(last_ovf == 1'b1, "dut_ovf_flag", last_ovf, 1);
`ifdef NR_DIV_SAT_EN
      chk(last_q == 32'h7FFF_FFFF, "dut_ovf_sat", last_q, 32'h7FFF_FFFF);
`else
      chk(last_q[31:28] == 4'h1, "dut_ovf_wrap", last_q, 32'h1000_0000);
`endif

      for (int i = 0; i < NV; i++) begin
         send(vdd[i], vds[i]);
         drain();
      end

      acc_log.delete();
      for (int i = 0; i < 3; i++) send(32'h0580_0000 + 32'(i) * 32'h0010_0000, 32'h0040_0000);
      drain();
      for (int i = 1; i < 3; i++)
         chk(acc_log[i] - acc_log[i-1] == PERIOD, "throughput", acc_log[i] - acc_log[i-1], PERIOD);

      out_ready = 1'b0;
      send(32'h0300_0000, 32'hFE80_0000);
      begin
         int guard;
         guard = 0;
         while (!out_valid && guard < 100) begin
            @(posedge clk); #2;
            guard++;
         end
         chk(guard < 100, "hold_wait_timeout", guard, 100);
      end
      repeat (5) @(posedge clk);
      #2;
      chk(out_valid == 1'b1 && in_ready == 1'b0, "hold_still_done", {out_valid, in_ready}, 2'b10);
      out_ready = 1'b1;
      @(posedge clk); #2;
      chk(in_ready == 1'b1 && out_valid == 1'b0, "release_to_idle", {in_ready, out_valid}, 2'b10);
      drain();

      send(32'h0100_0000, 32'h0200_0000);
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b1;
      exp_q.delete();
      n_abort++;
      @(posedge clk); #2;
      rst = 1'b0;
      chk(q == '0 && dz == 1'b0 && ovf == 1'b0, "rst_mid_clears", q, 0);
      chk(out_valid == 1'b0, "rst_mid_no_valid", out_valid, 0);
      @(posedge clk); #2;
      chk(in_ready == 1'b1, "in_ready_after_rst", in_ready, 1);
      repeat (15) @(posedge clk);
      #2;
      send(32'h0100_0000, 32'h0200_0000);
      drain();
      chk(($signed(last_q - 32'h0080_0000) <= 2) && ($signed(last_q - 32'h0080_0000) >= -2),
          "after_rst_1_div_2", last_q, 32'h0080_0000);
      chk(last_lat == LAT, "after_rst_latency", last_lat, LAT);

      chk(n_done == n_sent - n_abort, "result_count", n_done, n_sent - n_abort);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
